// File: rtl/uart_ram_loader.sv
// UART-fed bootloader: parses a framed load packet, writes little-endian
// 16-bit words into RAM port A and holds the CPU in reset until a good load.
module uart_ram_loader #(
   parameter logic [7:0]  MAGIC          = 8'hB5,
   parameter int unsigned ADDR_W         = 13,
   parameter int unsigned TIMEOUT_CYCLES = 2700000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [15:0]       ram_din,
   output logic              cpu_hold,
   output logic              busy,
   output logic              load_done,
   output logic              load_error,
   output logic [1:0]        error_code
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned END_W = 17;
   localparam logic [END_W-1:0] DEPTH = END_W'(2 ** ADDR_W);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0] ERR_CHK   = 2'b01;
   localparam logic [1:0] ERR_RANGE = 2'b10;
   localparam logic [1:0] ERR_TMO   = 2'b11;

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR_LO, S_ADDR_HI, S_LEN_LO, S_LEN_HI,
      S_DATA_LO, S_DATA_HI, S_CHK, S_DONE, S_ERROR
   } state_t;

   state_t              state_q, state_d;
   logic [7:0]          lo_q, lo_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [15:0]         cnt_q, cnt_d;
   logic [7:0]          sum_q, sum_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic                ram_we_q, ram_we_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [15:0]         ram_din_q, ram_din_d;
   logic                cpu_hold_q, cpu_hold_d;
   logic                busy_q, busy_d;
   logic                load_done_q, load_done_d;
   logic                load_error_q, load_error_d;
   logic [1:0]          error_code_q, error_code_d;

   logic                in_frame;
   logic                err;
   logic [1:0]          err_code;
   logic [15:0]         byte_word;
   logic [END_W-1:0]    end_addr;
   logic [7:0]          sum_next;

   // Helper values derived from the current byte and held state
   assign in_frame  = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
   assign byte_word = {rx_data, lo_q};
   assign end_addr  = END_W'(addr_q) + END_W'(byte_word);
   assign sum_next  = sum_q + rx_data;

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         lo_q         <= '0;
         addr_q       <= '0;
         cnt_q        <= '0;
         sum_q        <= '0;
         tmo_q        <= '0;
         ram_we_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_din_q    <= '0;
         cpu_hold_q   <= 1'b1;
         busy_q       <= 1'b0;
         load_done_q  <= 1'b0;
         load_error_q <= 1'b0;
         error_code_q <= 2'b00;
      end else begin
         state_q      <= state_d;
         lo_q         <= lo_d;
         addr_q       <= addr_d;
         cnt_q        <= cnt_d;
         sum_q        <= sum_d;
         tmo_q        <= tmo_d;
         ram_we_q     <= ram_we_d;
         ram_addr_q   <= ram_addr_d;
         ram_din_q    <= ram_din_d;
         cpu_hold_q   <= cpu_hold_d;
         busy_q       <= busy_d;
         load_done_q  <= load_done_d;
         load_error_q <= load_error_d;
         error_code_q <= error_code_d;
      end
   end

   // Frame parser: next state, write strobe, status flags and idle timeout
   always_comb begin
      state_d      = state_q;
      lo_d         = lo_q;
      addr_d       = addr_q;
      cnt_d        = cnt_q;
      sum_d        = sum_q;
      tmo_d        = '0;
      ram_we_d     = 1'b0;
      ram_addr_d   = ram_addr_q;
      ram_din_d    = ram_din_q;
      cpu_hold_d   = cpu_hold_q;
      busy_d       = busy_q;
      load_done_d  = load_done_q;
      load_error_d = load_error_q;
      error_code_d = error_code_q;
      err          = 1'b0;
      err_code     = 2'b00;

      if (in_frame && !rx_valid) begin
         tmo_d = tmo_q + TMO_W'(1);
      end

      if (rx_valid) begin
         case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
               if (rx_data == MAGIC) begin
                  state_d      = S_ADDR_LO;
                  sum_d        = '0;
                  load_done_d  = 1'b0;
                  load_error_d = 1'b0;
                  error_code_d = 2'b00;
                  busy_d       = 1'b1;
                  cpu_hold_d   = 1'b1;
               end
            end
            S_ADDR_LO: begin
               lo_d    = rx_data;
               sum_d   = sum_next;
               state_d = S_ADDR_HI;
            end
            S_ADDR_HI: begin
               sum_d = sum_next;
               if ((byte_word >> ADDR_W) != 16'd0) begin
                  err      = 1'b1;
                  err_code = ERR_RANGE;
               end else begin
                  addr_d  = ADDR_W'(byte_word);
                  state_d = S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               lo_d    = rx_data;
               sum_d   = sum_next;
               state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
               sum_d = sum_next;
               cnt_d = byte_word;
               if (end_addr > DEPTH) begin
                  err      = 1'b1;
                  err_code = ERR_RANGE;
               end else if (byte_word == 16'd0) begin
                  state_d = S_CHK;
               end else begin
                  state_d = S_DATA_LO;
               end
            end
            S_DATA_LO: begin
               lo_d    = rx_data;
               sum_d   = sum_next;
               state_d = S_DATA_HI;
            end
            S_DATA_HI: begin
               sum_d      = sum_next;
               ram_we_d   = 1'b1;
               ram_addr_d = addr_q;
               ram_din_d  = byte_word;
               addr_d     = addr_q + ADDR_W'(1);
               cnt_d      = cnt_q - 16'd1;
               state_d    = (cnt_q == 16'd1) ? S_CHK : S_DATA_LO;
            end
            S_CHK: begin
               if (sum_next == 8'd0) begin
                  state_d     = S_DONE;
                  load_done_d = 1'b1;
                  busy_d      = 1'b0;
                  cpu_hold_d  = 1'b0;
               end else begin
                  err      = 1'b1;
                  err_code = ERR_CHK;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end else if (in_frame && (tmo_q == TMO_LAST)) begin
         err      = 1'b1;
         err_code = ERR_TMO;
      end

      if (err) begin
         state_d      = S_ERROR;
         load_error_d = 1'b1;
         error_code_d = err_code;
         busy_d       = 1'b0;
         cpu_hold_d   = 1'b1;
         tmo_d        = '0;
      end
   end

   assign ram_we     = ram_we_q;
   assign ram_addr   = ram_addr_q;
   assign ram_din    = ram_din_q;
   assign cpu_hold   = cpu_hold_q;
   assign busy       = busy_q;
   assign load_done  = load_done_q;
   assign load_error = load_error_q;
   assign error_code = error_code_q;

endmodule

// File: tb/tb_uart_ram_loader.sv
// Randomized scoreboard bench for uart_ram_loader.
module tb_uart_ram_loader;

   localparam int unsigned ADDR_W = 13;
   localparam int unsigned T      = 100;
   localparam int          DEPTH  = 8192;
   localparam logic [7:0]  MAGIC  = 8'hB5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [15:0]       ram_din;
   logic              cpu_hold;
   logic              busy;
   logic              load_done;
   logic              load_error;
   logic [1:0]        error_code;

   typedef struct {
      logic [12:0] addr;
      logic [15:0] data;
      int          cyc;
   } exp_t;

   exp_t        expq[$];
   logic [15:0] wq[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          last_stamp = 0;

   uart_ram_loader #(.MAGIC(MAGIC), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
      .cpu_hold(cpu_hold), .busy(busy), .load_done(load_done),
      .load_error(load_error), .error_code(error_code)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every write pulse must match the next expected write
   always @(negedge clk) begin
      if (ram_we === 1'b1) begin
         if (expq.size() == 0) begin
            cmp("unexpected_write_addr", 32'(ram_addr), 32'hFFFFFFFF);
         end else begin
            exp_t e;
            e = expq.pop_front();
            cmp("write_addr", 32'(ram_addr), 32'(e.addr));
            cmp("write_data", 32'(ram_din), 32'(e.data));
            cmp("write_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present one byte for exactly one clock; called just after a rising edge
   task automatic drive(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk);
      #1;
      rx_valid   = 1'b0;
      last_stamp = cyc;
   endtask

   task automatic check_status(input string tag, input logic done, input logic err,
                               input logic [1:0] code, input logic hold, input logic bsy);
      cmp({tag, ".load_done"},  32'(load_done),  32'(done));
      cmp({tag, ".load_error"}, 32'(load_error), 32'(err));
      cmp({tag, ".error_code"}, 32'(error_code), 32'(code));
      cmp({tag, ".cpu_hold"},   32'(cpu_hold),   32'(hold));
      cmp({tag, ".busy"},       32'(busy),       32'(bsy));
   endtask

   task automatic check_reset(input string tag);
      cmp({tag, ".ram_we"},   32'(ram_we),   32'd0);
      cmp({tag, ".ram_addr"}, 32'(ram_addr), 32'd0);
      cmp({tag, ".ram_din"},  32'(ram_din),  32'd0);
      check_status(tag, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
   endtask

   // Reference model: sends a whole frame built from wq and predicts the outcome
   task automatic send_frame(input string tag, input int start, input int len, input int delta);
      logic [15:0] s;
      logic [15:0] n;
      logic [15:0] w;
      logic [7:0]  chk;
      int          sum;
      s   = 16'(start);
      n   = 16'(len);
      sum = 0;
      drive(MAGIC);             idle($urandom_range(1, 3));
      drive(s[7:0]);            idle($urandom_range(1, 3));
      drive(s[15:8]);
      sum = sum + int'(s[7:0]) + int'(s[15:8]);
      if (start >= DEPTH) begin
         check_status({tag, ".addr_range"}, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0);
         idle(1);
         return;
      end
      idle($urandom_range(1, 3));
      drive(n[7:0]);            idle($urandom_range(1, 3));
      drive(n[15:8]);
      sum = sum + int'(n[7:0]) + int'(n[15:8]);
      if (start + len > DEPTH) begin
         check_status({tag, ".len_range"}, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0);
         idle(1);
         return;
      end
      check_status({tag, ".in_frame"}, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
      idle($urandom_range(1, 3));
      for (int i = 0; i < len; i++) begin
         w = wq[i];
         drive(w[7:0]);         idle($urandom_range(1, 3));
         drive(w[15:8]);
         expq.push_back('{addr: 13'(start + i), data: w, cyc: last_stamp});
         sum = sum + int'(w[7:0]) + int'(w[15:8]);
         idle($urandom_range(1, 3));
      end
      chk = 8'((256 - (sum % 256) + delta) % 256);
      drive(chk);
      if (delta % 256 == 0) check_status({tag, ".good"}, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
      else                  check_status({tag, ".bad_chk"}, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0);
      idle(1);
   endtask

   // MAGIC, addr 0, len 1, then the low data byte
   task automatic one_word_header(input logic [7:0] lo);
      drive(MAGIC); idle(1);
      drive(8'h00); idle(1);
      drive(8'h00); idle(1);
      drive(8'h01); idle(1);
      drive(8'h00); idle(1);
      drive(lo);
   endtask

   initial begin
      int start;
      int len;
      int delta;
      logic [7:0] lo;
      logic [7:0] hi;
      logic [7:0] c;
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_reset("reset");
      rst_n = 1'b1;
      idle(2);

      wq = '{16'h1234, 16'hABCD, 16'h0041};
      send_frame("basic_good", 0, 3, 0);
      send_frame("basic_badchk", 0, 3, 1);
      send_frame("range_1ffe", 16'h1FFE, 3, 0);
      send_frame("addr_2000", 16'h2000, 1, 0);

      drive(8'h00); idle(1);
      drive(8'hFF); idle(1);
      drive(8'h12);
      check_status("leading_ignored", 1'b0, 1'b1, 2'b10, 1'b1, 1'b0);
      idle(1);
      wq = '{16'h5A5A};
      send_frame("one_word", 16'h0100, 1, 0);

      wq = '{16'hB5B5, 16'h00B5, 16'hB500};
      send_frame("magic_as_data", 16'h1FFD, 3, 0);
      send_frame("len_zero", 16'h0042, 0, 0);

      // Idle timeout: error exactly T cycles after the last byte
      one_word_header(8'h77);
      repeat (T - 1) @(posedge clk);
      #1;
      check_status("tmo_before", 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      check_status("tmo_hit", 1'b0, 1'b1, 2'b11, 1'b1, 1'b0);
      idle(1);
      wq = '{16'hC0DE};
      send_frame("after_tmo", 16'h0010, 1, 0);

      // A byte arriving on the limit cycle wins over the timeout
      lo = 8'h11;
      hi = 8'h22;
      one_word_header(lo);
      repeat (T - 1) @(posedge clk);
      #1;
      drive(hi);
      expq.push_back('{addr: 13'd0, data: {hi, lo}, cyc: last_stamp});
      check_status("tmo_byte_wins", 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
      idle(1);
      c = 8'(256 - ((1 + int'(lo) + int'(hi)) % 256));
      drive(c);
      check_status("tmo_byte_wins_end", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
      idle(1);

      // Reset in the middle of a 4-word frame
      drive(MAGIC); idle(1);
      drive(8'h20); idle(1);
      drive(8'h00); idle(1);
      drive(8'h04); idle(1);
      drive(8'h00); idle(1);
      for (int i = 0; i < 2; i++) begin
         drive(8'(8'h10 + i)); idle(1);
         drive(8'hEE);
         expq.push_back('{addr: 13'(16'h20 + i), data: {8'hEE, 8'(8'h10 + i)}, cyc: last_stamp});
         idle(1);
      end
      drive(8'h99);
      rst_n = 1'b0;
      #1;
      check_reset("mid_frame_reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);
      drive(8'h00);
      check_reset("no_magic_after_reset");
      idle(1);
      wq = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
      send_frame("after_reset", 16'h0020, 4, 0);

      for (int k = 0; k < 8; k++) begin
         start = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 65535))
                                             : int'($urandom_range(8180, 8191));
         if (k < 3) start = int'($urandom_range(0, 8191));
         len   = int'($urandom_range(0, 6));
         delta = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 255)) : 0;
         wq.delete();
         for (int i = 0; i < len; i++) wq.push_back(16'($urandom));
         send_frame($sformatf("rand%0d", k), start, len, delta);
      end

      idle(3);
      cmp("pending_writes", 32'(expq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
